switch_poll_ctrl: RTL and testbench

- Sequences periodic reads of the switches PIO (32-bit input port, registered readdata, 2-bit address, 1-cycle read latency).
- Debounces each sample, keeps a stable switch image and per-bit change-capture flags, and raises an interrupt to the Nios II.
- Nios II sees a 4-word Avalon-MM slave; the switches PIO's address/readdata are driven only by this block.

---
 rtl/switch_poll_if.sv | 21 ++
 rtl/switch_poll_ctrl.sv | 82 ++++++++
 tb/tb_switch_poll_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_poll_if.sv
// switch_poll_if: CPU slave port and switches PIO read port of switch_poll_ctrl.
interface switch_poll_if #(
   parameter int DATA_WIDTH = 32
);
   logic [1:0]            pio_address;
   logic [DATA_WIDTH-1:0] pio_readdata;
   logic [1:0]            s_address;
   logic                  s_chipselect;
   logic                  s_write_n;
   logic [DATA_WIDTH-1:0] s_writedata;
   logic [DATA_WIDTH-1:0] s_readdata;
   logic                  irq;
   modport slave (
      output pio_address, s_readdata, irq,
      input  pio_readdata, s_address, s_chipselect, s_write_n, s_writedata
   );
   modport master (
      input  pio_address, s_readdata, irq,
      output pio_readdata, s_address, s_chipselect, s_write_n, s_writedata
   );
endinterface

// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl: periodically reads the switches PIO, debounces the image,
// latches per-bit change flags and interrupts the CPU through a 4-word slave.
module switch_poll_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEFAULT_PERIOD = 50000,
   parameter int STABLE_COUNT   = 4
) (
   input logic          clk,
   input logic          reset_n,
   switch_poll_if.slave bus
);
   typedef enum logic [1:0] {WAIT, ADDR, CAPTURE, EVAL} state_t;
   localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

   state_t                state, state_nxt;
   logic [31:0]           period, timer, timer_nxt, period_wr;
   logic [3:0]            stable_cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] sample, candidate, debounced, edge_flags, mask;
   logic [DATA_WIDTH-1:0] new_edges, clr_edges, rd_mux;
   logic                  wr, rd, same, accept;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= WAIT;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT:    state_nxt = (timer == '0) ? ADDR : WAIT;
         ADDR:    state_nxt = CAPTURE;
         CAPTURE: state_nxt = EVAL;
         EVAL:    state_nxt = WAIT;
      endcase
      bus.pio_address = (state == ADDR || state == CAPTURE) ? 2'd0 : 2'd1;
   end

   always_comb begin
      wr        = bus.s_chipselect & ~bus.s_write_n;
      rd        = bus.s_chipselect & bus.s_write_n;
      period_wr = (bus.s_writedata == '0) ? 32'd1 : 32'(bus.s_writedata);
      // a period write restarts the countdown but never disturbs a poll in flight
      timer_nxt = (wr && bus.s_address == 2'd3) ? period_wr - 32'd1
                : (state == WAIT && timer == '0) ? period - 32'd1
                : (timer != '0) ? timer - 32'd1 : timer;
      same      = sample == candidate;
      cnt_nxt   = !same ? 4'd1 : (stable_cnt == STABLE) ? STABLE : stable_cnt + 4'd1;
      accept    = state == EVAL && cnt_nxt == STABLE && candidate != debounced;
      new_edges = accept ? (debounced ^ candidate) : '0;
      clr_edges = (wr && bus.s_address == 2'd2) ? bus.s_writedata : '0;
      rd_mux    = (bus.s_address == 2'd0) ? debounced
                : (bus.s_address == 2'd1) ? mask
                : (bus.s_address == 2'd2) ? edge_flags : DATA_WIDTH'(period);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         period         <= 32'(DEFAULT_PERIOD);
         timer          <= 32'(DEFAULT_PERIOD - 1);
         sample         <= '0;
         candidate      <= '0;
         stable_cnt     <= '0;
         debounced      <= '0;
         edge_flags     <= '0;
         mask           <= '0;
         bus.irq        <= 1'b0;
         bus.s_readdata <= '0;
      end else begin
         timer <= timer_nxt;
         if (state == CAPTURE) sample <= bus.pio_readdata;
         if (state == EVAL) begin
            candidate  <= same ? candidate : sample;
            stable_cnt <= cnt_nxt;
         end
         if (accept) debounced <= candidate;
         // a new change outranks a simultaneous CPU clear of the same bit
         edge_flags <= (edge_flags & ~clr_edges) | new_edges;
         if (wr && bus.s_address == 2'd1) mask <= bus.s_writedata;
         if (wr && bus.s_address == 2'd3) period <= period_wr;
         bus.irq        <= |(edge_flags & mask);
         bus.s_readdata <= rd ? rd_mux : '0;
      end
endmodule

// File: tb/tb_switch_poll_ctrl.sv
// tb_switch_poll_ctrl: register vectors plus hand-written polling sequences,
// with CPU reads checked through an expected-value queue.
module tb_switch_poll_ctrl;
   localparam int DW = 32;

   typedef struct {
      logic          wr;
      logic [1:0]    addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
      string         name;
   } vec_t;
   typedef struct {
      string         name;
      logic [DW-1:0] exp;
   } sb_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] in_port = '0;
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   sb_t           sb[$];

   switch_poll_if #(.DATA_WIDTH(DW)) bus ();
   switch_poll_ctrl #(.DATA_WIDTH(DW), .DEFAULT_PERIOD(50000), .STABLE_COUNT(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // switches PIO: registered readdata, port visible only at address 0
   always @(posedge clk or negedge reset_n)
      if (!reset_n) bus.pio_readdata <= '0;
      else bus.pio_readdata <= (bus.pio_address == 2'd0) ? in_port : '0;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [DW-1:0] d);
      bus.s_address = a; bus.s_writedata = d; bus.s_chipselect = 1'b1; bus.s_write_n = 1'b0;
      @(negedge clk);
      bus.s_chipselect = 1'b0; bus.s_write_n = 1'b1;
   endtask

   task automatic cpu_read(input logic [1:0] a, input logic [DW-1:0] exp, input string name);
      sb_t e;
      sb.push_back('{name, exp});
      bus.s_address = a; bus.s_chipselect = 1'b1; bus.s_write_n = 1'b1;
      @(negedge clk);
      bus.s_chipselect = 1'b0;
      e = sb.pop_front();
      check(e.name, bus.s_readdata, e.exp);
   endtask

   task automatic wait_pio(input logic [1:0] v, output int n);
      n = 0;
      while (bus.pio_address !== v && n < 60000) begin
         @(negedge clk);
         n++;
      end
      if (bus.pio_address !== v) check("wait_timeout", DW'(bus.pio_address), DW'(v));
   endtask

   task automatic poll_wait();
      int n;
      wait_pio(2'd0, n);
      wait_pio(2'd1, n);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int   n, n1, n2, c0;
      vec_t tbl[7];
      bus.s_address = '0; bus.s_chipselect = 1'b0; bus.s_write_n = 1'b1; bus.s_writedata = '0;
      tbl[0] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "mask_rw"};
      tbl[1] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, "debounced_ro"};
      tbl[2] = '{1'b1, 2'd3, 32'h0, 32'h1, "period_zero"};
      tbl[3] = '{1'b1, 2'd3, 32'd7, 32'd7, "period_rw"};
      tbl[4] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, "edge_w1c_empty"};
      tbl[5] = '{1'b1, 2'd1, 32'h0, 32'h0, "mask_clear"};
      tbl[6] = '{1'b0, 2'd3, 32'h0, 32'd7, "period_hold"};

      // reset values and first poll at DEFAULT_PERIOD
      repeat (3) @(negedge clk);
      check("rst_irq", DW'(bus.irq), 0);
      check("rst_rdata", bus.s_readdata, 0);
      check("rst_pio", DW'(bus.pio_address), 1);
      reset_n = 1'b1;
      c0 = cyc;
      cpu_read(2'd3, 50000, "rst_period");
      cpu_read(2'd0, 0, "rst_debounced");
      wait_pio(2'd0, n);
      check("first_poll_delay", cyc - c0, 50000);

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].wr) cpu_write(tbl[i].addr, tbl[i].wdata);
         cpu_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
      end
      check("table_irq", DW'(bus.irq), 0);

      // clean change accepted on the 4th identical poll
      cpu_write(2'd3, 10);
      cpu_write(2'd1, 1);
      poll_wait();
      in_port = 32'h5;
      for (int p = 1; p <= 4; p++) begin
         poll_wait();
         if (p < 4) cpu_read(2'd0, 0, "clean_pre_accept");
      end
      check("clean_irq_lag", DW'(bus.irq), 0);
      @(negedge clk);
      check("clean_irq", DW'(bus.irq), 1);
      cpu_read(2'd0, 32'h5, "clean_debounced");
      cpu_read(2'd2, 32'h5, "clean_edge");

      // bouncing input, then 4 steady polls
      do_reset();
      cpu_write(2'd3, 10);
      for (int p = 0; p < 12; p++) begin
         in_port = (p < 8 && p % 2 == 1) ? 32'h0 : 32'h1;
         poll_wait();
         cpu_read(2'd0, (p == 11) ? 32'h1 : 32'h0, "bounce_debounced");
      end
      cpu_read(2'd2, 32'h1, "bounce_edge");
      cpu_write(2'd2, 32'h1);
      repeat (2) poll_wait();
      cpu_read(2'd2, 32'h0, "bounce_edge_once");
      cpu_read(2'd0, 32'h1, "bounce_hold");

      // W1C on the same edge as a new change: set wins
      do_reset();
      in_port = 32'h4;
      cpu_write(2'd1, 32'h4);
      cpu_write(2'd3, 10);
      repeat (3) poll_wait();
      wait_pio(2'd0, n);
      repeat (2) @(negedge clk);
      check("race_in_eval", DW'(bus.pio_address), 1);
      cpu_write(2'd2, 32'h4);
      check("race_irq_lag", DW'(bus.irq), 0);
      @(negedge clk);
      check("race_irq", DW'(bus.irq), 1);
      cpu_read(2'd2, 32'h4, "race_edge_kept");
      check("race_irq_hold", DW'(bus.irq), 1);
      cpu_write(2'd2, 32'h4);
      check("clear_irq_lag", DW'(bus.irq), 1);
      @(negedge clk);
      check("clear_irq", DW'(bus.irq), 0);
      cpu_read(2'd2, 32'h0, "clear_edge");

      // minimum period and reload during CAPTURE
      do_reset();
      in_port = 32'h0;
      cpu_write(2'd3, 0);
      cpu_read(2'd3, 1, "period_min");
      wait_pio(2'd1, n);
      wait_pio(2'd0, n);
      for (int k = 0; k < 2; k++) begin
         wait_pio(2'd1, n1);
         wait_pio(2'd0, n2);
         check("poll_spacing", n1 + n2, 4);
      end
      @(negedge clk);
      check("in_capture", DW'(bus.pio_address), 0);
      cpu_write(2'd3, 100);
      check("capture_completes", DW'(bus.pio_address), 1);
      wait_pio(2'd0, n);
      check("period_reload", n, 100);
      cpu_read(2'd3, 100, "period_100");

      // async reset during CAPTURE
      in_port = 32'h3;
      cpu_write(2'd1, 32'hFF);
      cpu_write(2'd3, 0);
      repeat (5) poll_wait();
      cpu_read(2'd0, 32'h3, "pre_rst_debounced");
      cpu_read(2'd2, 32'h3, "pre_rst_edge");
      check("pre_rst_irq", DW'(bus.irq), 1);
      wait_pio(2'd1, n);
      wait_pio(2'd0, n);
      @(negedge clk);
      check("rst_in_capture", DW'(bus.pio_address), 0);
      reset_n = 1'b0;
      #1;
      check("rst_pio_async", DW'(bus.pio_address), 1);
      check("rst_irq_async", DW'(bus.irq), 0);
      @(negedge clk);
      reset_n = 1'b1;
      cpu_read(2'd2, 0, "post_rst_edge");
      cpu_read(2'd1, 0, "post_rst_mask");
      cpu_read(2'd0, 0, "post_rst_debounced");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
